sram_mem_controller: RTL and testbench

- Memory-stage controller between the pipeline's MEM stage and an external 16-bit asynchronous SRAM.
- Converts each 32-bit load/store into two timed half-word SRAM accesses.
- Drives `ready`; the top level feeds `~ready` into the freeze input of the pipeline stage registers, stalling the core while an access is in flight.

---
 rtl/sram_mem_controller_if.sv | 28 ++
 rtl/sram_mem_controller.sv | 126 ++++++++++++
 tb/tb_sram_mem_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_controller_if.sv
// MEM-stage request bus and external 16-bit SRAM pins seen by the SRAM memory controller.
interface sram_mem_controller_if #(
  parameter int unsigned SRAM_AW = 18
);
  logic               rd_en;
  logic               wr_en;
  logic [31:0]        address;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;

  // Pipeline side plus the SRAM device model
  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  // Controller side
  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage load/store into two timed half-word accesses on a 16-bit
// asynchronous SRAM; ready is low while an access is in flight so the core freezes.
module sram_mem_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input logic                  clk,
  input logic                  rst,
  sram_mem_controller_if.slave bus
);

  localparam int unsigned   CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [31:0]   BASE     = 32'(ADDR_BASE);

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               op_wr, op_wr_nxt;
  logic [31:0]        op_addr, op_addr_nxt;
  logic [31:0]        op_data, op_data_nxt;
  logic [31:0]        rd_q, rd_nxt;
  logic [SRAM_AW-1:0] addr_q, addr_nxt;
  logic [15:0]        dq_q, dq_nxt;
  logic               oe_q, oe_nxt;
  logic               we_n_q, we_n_nxt;
  logic               req;
  logic               last;

  assign req  = bus.rd_en | bus.wr_en;
  assign last = (cnt == CNT_LAST);

  // Half-word SRAM address; addresses below the base wrap silently
  function automatic logic [SRAM_AW-1:0] half_addr(input logic [31:0] a, input logic hi);
    return SRAM_AW'({(a - BASE) >> 2, hi});
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req)  next_state = LOW;
      LOW:     if (last) next_state = HIGH;
      HIGH:    if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output registers are loaded with the values of the phase being entered
  always_comb begin
    cnt_nxt     = cnt;
    op_wr_nxt   = op_wr;
    op_addr_nxt = op_addr;
    op_data_nxt = op_data;
    rd_nxt      = rd_q;
    addr_nxt    = addr_q;
    dq_nxt      = dq_q;
    oe_nxt      = 1'b0;
    we_n_nxt    = 1'b1;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt     = '0;
          op_wr_nxt   = bus.wr_en;
          op_addr_nxt = bus.address;
          op_data_nxt = bus.write_data;
        end
      end
      LOW, HIGH: begin
        cnt_nxt = last ? '0 : cnt + CNT_W'(1);
        if (last && !op_wr) begin
          if (state == LOW) rd_nxt[15:0]  = bus.sram_dq_in;
          else              rd_nxt[31:16] = bus.sram_dq_in;
        end
      end
      default: ;
    endcase
    if (next_state == LOW || next_state == HIGH) begin
      addr_nxt = half_addr(op_addr_nxt, next_state == HIGH);
      if (op_wr_nxt) begin
        dq_nxt   = (next_state == HIGH) ? op_data_nxt[31:16] : op_data_nxt[15:0];
        oe_nxt   = 1'b1;
        we_n_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      op_wr   <= 1'b0;
      op_addr <= '0;
      op_data <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      cnt     <= cnt_nxt;
      op_wr   <= op_wr_nxt;
      op_addr <= op_addr_nxt;
      op_data <= op_data_nxt;
      rd_q    <= rd_nxt;
      addr_q  <= addr_nxt;
      dq_q    <= dq_nxt;
      oe_q    <= oe_nxt;
      we_n_q  <= we_n_nxt;
    end
  end

  assign bus.ready       = ((state == IDLE) && !req) || (state == DONE);
  assign bus.read_data   = rd_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_q;
  assign bus.sram_dq_oe  = oe_q;
  assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances, each against
// a transaction-level model and a simple SRAM device, plus directed literal expectations.
module tb_sram_mem_controller;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sram_mem_controller_if #(.SRAM_AW(18)) bus2 ();
  sram_mem_controller_if #(.SRAM_AW(18)) bus0 ();

  sram_mem_controller #(.WAIT_CYCLES(2), .ADDR_BASE(1024), .SRAM_AW(18)) u_w2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );
  sram_mem_controller #(.WAIT_CYCLES(0), .ADDR_BASE(1024), .SRAM_AW(18)) u_w0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unwritten SRAM locations return a pattern derived from their address
  function automatic logic [15:0] dflt(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // SRAM devices
  bit          wr2 [0:262143];
  logic [15:0] mem2 [0:262143];
  bit          wr0 [0:262143];
  logic [15:0] mem0 [0:262143];

  always @(posedge clk) begin
    if (bus2.sram_we_n === 1'b0) begin
      mem2[bus2.sram_addr] <= bus2.sram_dq_out;
      wr2[bus2.sram_addr]  <= 1'b1;
    end
    if (bus0.sram_we_n === 1'b0) begin
      mem0[bus0.sram_addr] <= bus0.sram_dq_out;
      wr0[bus0.sram_addr]  <= 1'b1;
    end
  end

  assign bus2.sram_dq_in = wr2[bus2.sram_addr] ? mem2[bus2.sram_addr] : dflt(bus2.sram_addr);
  assign bus0.sram_dq_in = wr0[bus0.sram_addr] ? mem0[bus0.sram_addr] : dflt(bus0.sram_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Model index 0 = WAIT_CYCLES 2 instance, 1 = WAIT_CYCLES 0 instance.
  // el counts cycles since the request was taken: phases 1..w+1 low, w+2..2w+2 high, 2w+3 done.
  bit          busy     [2];
  int          el       [2];
  bit          wr_op    [2];
  logic [31:0] op_a     [2];
  logic [31:0] op_d     [2];
  logic [31:0] exp_rd   [2];
  logic [17:0] exp_addr [2];
  logic [15:0] shadow   [int];

  function automatic int wof(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [17:0] mhalf(input logic [31:0] a, input bit hi);
    logic [31:0] off;
    off = a - 32'd1024;
    return 18'((off / 4) * 2 + 32'(hi));
  endfunction

  function automatic logic [15:0] shadow_rd(input int i, input logic [17:0] a);
    int key;
    key = i * 262144 + int'(a);
    return shadow.exists(key) ? shadow[key] : dflt(a);
  endfunction

  task automatic model_step(input int i, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
    int w;
    w = wof(i);
    if (!busy[i]) begin
      if (rd || wr) begin
        busy[i] = 1'b1; el[i] = 1; wr_op[i] = wr; op_a[i] = a; op_d[i] = d;
      end
    end else begin
      if (el[i] == w + 1) begin
        if (wr_op[i]) shadow[i * 262144 + int'(mhalf(op_a[i], 1'b0))] = op_d[i][15:0];
        else          exp_rd[i][15:0] = shadow_rd(i, mhalf(op_a[i], 1'b0));
      end
      if (el[i] == 2 * w + 2) begin
        if (wr_op[i]) shadow[i * 262144 + int'(mhalf(op_a[i], 1'b1))] = op_d[i][31:16];
        else          exp_rd[i][31:16] = shadow_rd(i, mhalf(op_a[i], 1'b1));
      end
      if (el[i] == 2 * w + 3) busy[i] = 1'b0;
      else                    el[i]++;
    end
    if (busy[i] && el[i] <= 2 * w + 2) exp_addr[i] = mhalf(op_a[i], el[i] > w + 1);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        busy[i] = 1'b0; el[i] = 0; exp_rd[i] = '0; exp_addr[i] = '0;
      end
    end else begin
      model_step(0, bus2.rd_en, bus2.wr_en, bus2.address, bus2.write_data);
      model_step(1, bus0.rd_en, bus0.wr_en, bus0.address, bus0.write_data);
    end
  end

  task automatic cmp(input int i, input logic rq, input logic rdy, input logic [31:0] rdat,
                     input logic [17:0] sa, input logic [15:0] dq, input logic oe, input logic we_n);
    int w;
    bit inl, inh, wact;
    w    = wof(i);
    inl  = busy[i] && (el[i] <= w + 1);
    inh  = busy[i] && (el[i] > w + 1) && (el[i] <= 2 * w + 2);
    wact = (inl || inh) && wr_op[i];
    chk($sformatf("m%0d.ready", i), 32'(rdy),
        32'((!busy[i] && !rq) || (busy[i] && el[i] == 2 * w + 3)));
    chk($sformatf("m%0d.read_data", i), rdat, exp_rd[i]);
    chk($sformatf("m%0d.sram_addr", i), 32'(sa), 32'(exp_addr[i]));
    chk($sformatf("m%0d.we_n", i), 32'(we_n), 32'(!wact));
    chk($sformatf("m%0d.oe", i), 32'(oe), 32'(wact));
    if (wact) chk($sformatf("m%0d.dq_out", i), 32'(dq), 32'(inl ? op_d[i][15:0] : op_d[i][31:16]));
  endtask

  always @(negedge clk) begin
    cmp(0, bus2.rd_en | bus2.wr_en, bus2.ready, bus2.read_data, bus2.sram_addr,
        bus2.sram_dq_out, bus2.sram_dq_oe, bus2.sram_we_n);
    cmp(1, bus0.rd_en | bus0.wr_en, bus0.ready, bus0.read_data, bus0.sram_addr,
        bus0.sram_dq_out, bus0.sram_dq_oe, bus0.sram_we_n);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // One access on the WAIT_CYCLES=2 instance; request shown for cycle 0 only, then scrambled inputs
  task automatic run2(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rdat, input logic [17:0] lo);
    bus2.rd_en = rd; bus2.wr_en = wr; bus2.address = a; bus2.write_data = d;
    for (int k = 0; k <= 8; k++) begin
      at_neg();
      chk($sformatf("lit.ready k%0d", k), 32'(bus2.ready), 32'(k >= 7));
      if (k >= 1 && k <= 6) begin
        chk($sformatf("lit.addr k%0d", k), 32'(bus2.sram_addr), 32'((k <= 3) ? lo : lo + 18'd1));
        chk($sformatf("lit.we_n k%0d", k), 32'(bus2.sram_we_n), 32'(!wr));
        chk($sformatf("lit.oe k%0d", k), 32'(bus2.sram_dq_oe), 32'(wr));
        if (wr) chk($sformatf("lit.dq k%0d", k), 32'(bus2.sram_dq_out),
                    32'((k <= 3) ? d[15:0] : d[31:16]));
      end else begin
        chk($sformatf("lit.we_n k%0d", k), 32'(bus2.sram_we_n), 32'd1);
      end
      if (k == 7) chk("lit.read_data", bus2.read_data, exp_rdat);
      cyc();
      if (k == 0) begin
        bus2.rd_en = 1'b0; bus2.wr_en = 1'b0;
        bus2.address = 32'hFFFF_FFF0; bus2.write_data = 32'h0BAD_F00D;
      end
    end
  endtask

  initial begin
    bit   [7:0]  pat;
    logic [17:0] atab [8];
    rst = 1'b1;
    bus2.rd_en = 1'b0; bus2.wr_en = 1'b0; bus2.address = '0; bus2.write_data = '0;
    bus0.rd_en = 1'b0; bus0.wr_en = 1'b0; bus0.address = '0; bus0.write_data = '0;
    #1 rst = 1'b0;
    bus2.rd_en = 1'b1; bus2.address = 32'h404;
    cyc(); cyc();
    at_neg();
    chk("rst.read_data", bus2.read_data, 32'h0);
    chk("rst.we_n", 32'(bus2.sram_we_n), 32'd1);
    chk("rst.oe", 32'(bus2.sram_dq_oe), 32'd0);
    chk("rst.sram_addr", 32'(bus2.sram_addr), 32'd0);
    chk("rst.ready_req", 32'(bus2.ready), 32'd0);
    cyc();
    rst = 1'b1;
    run2(1'b1, 1'b0, 32'h404, 32'h0, 32'h5A59_5A58, 18'd2);
    run2(1'b0, 1'b1, 32'h404, 32'hDEAD_BEEF, 32'h5A59_5A58, 18'd2);
    run2(1'b1, 1'b0, 32'h404, 32'h0, 32'hDEAD_BEEF, 18'd2);
    run2(1'b1, 1'b1, 32'h408, 32'h1234_5678, 32'hDEAD_BEEF, 18'd4);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("idle.ready", 32'(bus2.ready), 32'd1);
      cyc();
    end
    run2(1'b1, 1'b0, 32'h408, 32'h0, 32'h1234_5678, 18'd4);
    run2(1'b1, 1'b0, 32'h0, 32'h0, 32'hA45B_A45A, 18'h3FE00);

    // Reset during the high phase of a read
    bus2.rd_en = 1'b1; bus2.address = 32'h404;
    cyc();
    bus2.rd_en = 1'b0;
    repeat (5) cyc();
    rst = 1'b0;
    #1;
    chk("midrst.read_data", bus2.read_data, 32'h0);
    chk("midrst.we_n", 32'(bus2.sram_we_n), 32'd1);
    chk("midrst.oe", 32'(bus2.sram_dq_oe), 32'd0);
    chk("midrst.ready", 32'(bus2.ready), 32'd1);
    cyc(); cyc();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("postrst.ready", 32'(bus2.ready), 32'd1);
      cyc();
    end

    // Back-to-back loads with zero wait cycles
    pat = 8'b1000_1000;
    atab[0] = 18'd0; atab[1] = 18'd2; atab[2] = 18'd3; atab[3] = 18'd3;
    atab[4] = 18'd3; atab[5] = 18'd2; atab[6] = 18'd3; atab[7] = 18'd3;
    bus0.rd_en = 1'b1; bus0.address = 32'h404;
    for (int k = 0; k < 8; k++) begin
      at_neg();
      chk($sformatf("b2b.ready k%0d", k), 32'(bus0.ready), 32'(pat[k]));
      if (k >= 1) chk($sformatf("b2b.addr k%0d", k), 32'(bus0.sram_addr), 32'(atab[k]));
      cyc();
    end
    bus0.rd_en = 1'b0;
    at_neg();
    chk("b2b.read_data", bus0.read_data, 32'h5A59_5A58);
    chk("b2b.ready_idle", 32'(bus0.ready), 32'd1);
    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
